// File: rtl/pn_lfsr_sext_if.sv
// Control, sample and result bundle for the PN generator / sign-extension block.
interface pn_lfsr_sext_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned IN_BITS  = 16,
    parameter int unsigned OUT_BITS = 32
);
    logic                ena_i;
    logic                strobe_i;
    logic [WIDTH-1:0]    mask_i;
    logic [IN_BITS-1:0]  data_i;
    logic                pn_o;
    logic [OUT_BITS-1:0] ext_o;
    logic [OUT_BITS-1:0] prod_o;

    modport master (
        output ena_i, strobe_i, mask_i, data_i,
        input  pn_o, ext_o, prod_o
    );

    modport slave (
        input  ena_i, strobe_i, mask_i, data_i,
        output pn_o, ext_o, prod_o
    );
endinterface

// File: rtl/pn_lfsr_sext.sv
// PN chip generator (Fibonacci LFSR, runtime taps) with sample sign-extension
// and chip-polarity product for correlation accumulation.
module pn_lfsr_sext #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned IN_BITS  = 16,
    parameter int unsigned OUT_BITS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pn_lfsr_sext_if.slave   bus
);
    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

    logic [WIDTH-1:0]    r_shifter;
    logic                w_fb;
    logic [OUT_BITS-1:0] w_ext;
    logic [OUT_BITS-1:0] w_neg;

    // Feedback parity uses the mask presented at the same edge.
    assign w_fb = ^(r_shifter & bus.mask_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_shifter <= SEED;
        end else if (!bus.ena_i) begin
            r_shifter <= SEED;
        end else if (bus.strobe_i) begin
            r_shifter <= {r_shifter[WIDTH-2:0], w_fb};
        end
    end

    generate
        if (OUT_BITS > IN_BITS) begin : g_ext
            assign w_ext = {{(OUT_BITS-IN_BITS){bus.data_i[IN_BITS-1]}}, bus.data_i};
        end else begin : g_pass
            assign w_ext = bus.data_i;
        end
    endgenerate

    // Two's-complement negate wraps, so the most negative value maps to itself.
    assign w_neg = OUT_BITS'(0) - w_ext;

    assign bus.pn_o   = r_shifter[0];
    assign bus.ext_o  = w_ext;
    assign bus.prod_o = r_shifter[0] ? w_ext : w_neg;
endmodule

// File: tb/tb_pn_lfsr_sext.sv
// Directed plus randomized bench for pn_lfsr_sext against an arithmetic reference model.
module tb_pn_lfsr_sext;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned IN_BITS  = 16;
    localparam int unsigned OUT_BITS = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int unsigned m_state = 1;   // reference LFSR contents as a plain integer
    logic        chips[$];

    pn_lfsr_sext_if #(.WIDTH(WIDTH), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

    pn_lfsr_sext #(.WIDTH(WIDTH), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Next state: shift left (dropping the top bit) and append odd/even tap count.
    function automatic int unsigned model_next(int unsigned s, int unsigned m, bit ena, bit stb);
        if (!ena) return 1;
        if (!stb) return s;
        return ((s * 2) % 65536) + ($countones(s & m) % 2);
    endfunction

    function automatic logic [31:0] exp_ext(int unsigned d);
        longint v;
        v = (d >= 32768) ? longint'(d) - 65536 : longint'(d);
        return 32'(v);
    endfunction

    function automatic logic [31:0] exp_prod(int unsigned d, bit pn);
        longint v;
        v = (d >= 32768) ? longint'(d) - 65536 : longint'(d);
        return pn ? 32'(v) : 32'(-v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ena, input bit stb, input logic [15:0] mask, input logic [15:0] data);
        @(negedge clk);
        bus.ena_i    = ena;
        bus.strobe_i = stb;
        bus.mask_i   = mask;
        bus.data_i   = data;
        @(posedge clk);
        if (rst_n) m_state = model_next(m_state, mask, ena, stb);
        #1;
    endtask

    task automatic chk_all(input string tag);
        bit pn;
        pn = bit'(m_state % 2);
        chk({tag, "_pn"},   32'(bus.pn_o), 32'(pn));
        chk({tag, "_ext"},  bus.ext_o,     exp_ext(bus.data_i));
        chk({tag, "_prod"}, bus.prod_o,    exp_prod(bus.data_i, pn));
    endtask

    initial begin
        logic [31:0] exp_pn2 [4];
        exp_pn2[0] = 1; exp_pn2[1] = 0; exp_pn2[2] = 1; exp_pn2[3] = 1;

        bus.ena_i = 1'b0; bus.strobe_i = 1'b0; bus.mask_i = '0; bus.data_i = 16'h1234;
        #12;
        chk("reset_pn", 32'(bus.pn_o), 32'd1);
        chk("reset_prod", bus.prod_o, 32'h0000_1234);
        @(negedge clk);
        rst_n = 1'b1;

        // Walk to a state whose chip is 0, then reset asynchronously mid-cycle.
        step(1'b1, 1'b1, 16'h0003, 16'h0000);
        step(1'b1, 1'b1, 16'h0003, 16'h0000);
        chk("pre_reset_pn", 32'(bus.pn_o), 32'd0);
        #2 rst_n = 1'b0;
        m_state = 1;
        #1;
        chk("async_reset_pn", 32'(bus.pn_o), 32'd1);
        step(1'b1, 1'b1, 16'h0003, 16'h0000);
        chk("in_reset_hold_pn", 32'(bus.pn_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 16'h0003, 16'h0000);
        chk("ena_low_pn", 32'(bus.pn_o), 32'd1);

        // Sequence from seed with mask 0x0003, including hold gaps.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'h0003, 16'h0000);
            chk($sformatf("seq_pn%0d", i), 32'(bus.pn_o), exp_pn2[i]);
            if (i == 1) begin
                for (int h = 0; h < 10; h++) begin
                    step(1'b1, 1'b0, 16'h0003, 16'h0000);
                    chk($sformatf("hold_pn%0d", h), 32'(bus.pn_o), exp_pn2[1]);
                end
            end
        end

        // Absorbing zero: mask 0 shifts the seed out, then all-ones taps must stay 0.
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 16'h0000, 16'h0000);
            chk($sformatf("zero_pn%0d", i), 32'(bus.pn_o), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'hFFFF, 16'h0000);
            chk($sformatf("absorb_pn%0d", i), 32'(bus.pn_o), 32'd0);
        end

        // Degree-3 taps: chip stream must repeat every 7 chips.
        step(1'b0, 1'b0, 16'h0006, 16'h0000);
        chips.delete();
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 16'h0006, 16'h0000);
            chk($sformatf("m3_pn%0d", i), 32'(bus.pn_o), 32'(m_state % 2));
            chips.push_back(bus.pn_o);
        end
        for (int i = 10; i < 30; i++)
            chk($sformatf("m3_period%0d", i), 32'(chips[i]), 32'(chips[i-7]));

        // Sign-extension corners with chip 0 (state 0x0006) and chip 1.
        step(1'b0, 1'b0, 16'h0003, 16'h0000);
        step(1'b1, 1'b1, 16'h0003, 16'h0000);
        step(1'b1, 1'b1, 16'h0003, 16'h8000);
        chk("min_ext",  bus.ext_o,  32'hFFFF_8000);
        chk("min_prod", bus.prod_o, 32'h0000_8000);
        bus.data_i = 16'h7FFF; #1;
        chk("max_ext",  bus.ext_o,  32'h0000_7FFF);
        chk("max_prod", bus.prod_o, 32'hFFFF_8001);
        bus.data_i = 16'h0000; #1;
        chk("zero_prod_pn0", bus.prod_o, 32'h0);
        step(1'b1, 1'b1, 16'h0003, 16'h0000);
        chk("zero_prod_pn1", bus.prod_o, 32'h0);
        chk("pn1_state", 32'(bus.pn_o), 32'd1);

        // Randomized enables, strobes, masks and samples.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] mask;
            mask = (i % 50 < 25) ? 16'(32'hB400 | $urandom_range(0, 1)) : 16'($urandom);
            step($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0, mask, 16'($urandom));
            chk_all($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
